square_seq: RTL and testbench

//  Sequential shift-add squarer computing result = a*a. Inverse companion of the square-root unit;

---
 rtl/sq_pkg.sv | 22 ++
 rtl/control_square.sv | 93 +++++++++
 rtl/square_seq.sv | 81 ++++++++
 tb/tb_square_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sq_pkg.sv
// Shared definitions for the sequential shift-add squarer: controller state
// encodings and default parameter values.
package sq_pkg;

  typedef enum logic [2:0] {
    START   = 3'b000,
    CHECK   = 3'b001,
    ADD     = 3'b010,
    SHIFT   = 3'b011,
    CHECK_Z = 3'b100,
    END1    = 3'b101
  } sq_state_t;

  localparam int SQ_WIDTH_DEF     = 16;
  localparam int SQ_DONE_HOLD_DEF = 31;

  // Width of a counter that must be able to hold the value n.
  function automatic int sq_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/control_square.sv
// Controller for square_seq: sequences ld/add/sh over the shift-add datapath
// and holds done for DONE_HOLD cycles in END1 before returning to START.
module control_square
  import sq_pkg::*;
#(
  parameter int DONE_HOLD = SQ_DONE_HOLD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic b0,
  input  logic z,
  output logic done,
  output logic busy,
  output logic ld,
  output logic add,
  output logic sh,
  output logic ld_res
);

  localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  sq_state_t     state;
  sq_state_t     state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_nxt;
  logic          hold_last;

  // The last END1 cycle is the one where the counter reaches DONE_HOLD-1.
  assign hold_last = (hold_cnt == HW'(DONE_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= START;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = START;
    hold_cnt_nxt = hold_cnt;
    done         = 1'b0;
    busy         = 1'b0;
    ld           = 1'b0;
    add          = 1'b0;
    sh           = 1'b0;
    ld_res       = 1'b0;
    case (state)
      START: begin
        ld           = 1'b1;
        hold_cnt_nxt = '0;
        state_nxt    = init ? CHECK : START;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = b0 ? ADD : SHIFT;
      end
      ADD: begin
        busy      = 1'b1;
        add       = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        sh        = 1'b1;
        state_nxt = CHECK_Z;
      end
      CHECK_Z: begin
        busy = 1'b1;
        if (z) begin
          ld_res    = 1'b1;
          state_nxt = END1;
        end else begin
          state_nxt = CHECK;
        end
      end
      END1: begin
        done         = 1'b1;
        hold_cnt_nxt = hold_cnt + HW'(1);
        state_nxt    = hold_last ? START : END1;
      end
      default: begin
        // Unused encodings recover to START with every output low.
        state_nxt    = START;
        hold_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/square_seq.sv
// Sequential shift-add squarer, result = a*a, with an init/done handshake.
// Optional build macro SQ_EARLY_EXIT_EN ends iterating once the multiplier is exhausted.
module square_seq
  import sq_pkg::*;
#(
  parameter int WIDTH     = SQ_WIDTH_DEF,
  parameter int DONE_HOLD = SQ_DONE_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy
);

  localparam int CW = sq_cnt_w(WIDTH);

  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               ld;
  logic               add;
  logic               sh;
  logic               ld_res;
  logic               z;

  control_square #(
    .DONE_HOLD(DONE_HOLD)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .init   (init),
    .b0     (b_reg[0]),
    .z      (z),
    .done   (done),
    .busy   (busy),
    .ld     (ld),
    .add    (add),
    .sh     (sh),
    .ld_res (ld_res)
  );

  // Termination is judged on the post-shift multiplier and count.
`ifdef SQ_EARLY_EXIT_EN
  assign z = (cnt == CW'(WIDTH)) || (b_reg == '0);
`else
  assign z = (cnt == CW'(WIDTH));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      if (ld) begin
        a_reg <= {{WIDTH{1'b0}}, a};
        b_reg <= a;
        acc   <= '0;
        cnt   <= '0;
      end
      if (add) begin
        acc <= acc + a_reg;
      end
      if (sh) begin
        a_reg <= a_reg << 1;
        b_reg <= b_reg >> 1;
        cnt   <= cnt + CW'(1);
      end
      if (ld_res) begin
        result <= acc;
      end
    end
  end

endmodule

// File: tb/tb_square_seq.sv
// Scoreboard bench for square_seq: a driver pushes expected square and latency,
// a monitor pops and compares on every rising edge of done.
module tb_square_seq;

  localparam int WIDTH     = 16;
  localparam int DONE_HOLD = 31;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               init = 1'b0;
  logic [WIDTH-1:0]   a = '0;
  logic [2*WIDTH-1:0] result;
  logic               done;
  logic               busy;

  always #5 clk = ~clk;

  square_seq #(
    .WIDTH(WIDTH),
    .DONE_HOLD(DONE_HOLD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .init   (init),
    .a      (a),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  typedef struct {
    logic [WIDTH-1:0]   op;
    logic [2*WIDTH-1:0] exp;
    int                 start;
    int                 lat;
  } exp_t;

  exp_t               q[$];
  int                 n_checks = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  logic [2*WIDTH-1:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain arithmetic square and iteration-count latency.
  function automatic logic [2*WIDTH-1:0] model_square(input logic [WIDTH-1:0] v);
    longint unsigned x;
    x = longint'(v);
    return (2*WIDTH)'(x * x);
  endfunction

  function automatic int model_latency(input logic [WIDTH-1:0] v);
    int pc;
    int n;
    pc = 0;
    n  = WIDTH;
    for (int i = 0; i < WIDTH; i++) pc += int'(v[i]);
`ifdef SQ_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < WIDTH; i++) if (v[i]) n = i + 1;
`endif
    return 3 * n + pc;
  endfunction

  // Monitor: compares on done rise, checks hold length and stability on fall.
  initial begin
    logic               done_q;
    int                 hold_len;
    logic [2*WIDTH-1:0] held;
    logic               stable;
    exp_t               e;
    done_q   = 1'b0;
    hold_len = 0;
    held     = '0;
    stable   = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_q = 1'b0;
      end else begin
        if (done === 1'b1 && busy === 1'b1) check("done_busy_exclusive", busy, 1'b0);
        if (done === 1'b1 && done_q !== 1'b1) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 result=%0h, expected no done (cycle %0d)", result, cyc);
          end else begin
            e = q.pop_front();
            check("result", result, e.exp);
            check("latency", cyc - e.start, e.lat);
          end
          hold_len = 1;
          held     = result;
          stable   = 1'b1;
        end else if (done === 1'b1) begin
          hold_len++;
          if (result !== held) stable = 1'b0;
        end else if (done_q === 1'b1) begin
          check("done_len", hold_len, DONE_HOLD);
          check("result_stable_while_done", stable, 1'b1);
          check("start_after_end1", busy, 1'b0);
        end
        done_q = done;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%b done=%b, expected both 0 within %0d cycles", busy, done, budget);
    end
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] v);
    exp_t e;
    e.op    = v;
    e.exp   = model_square(v);
    e.start = cyc;
    e.lat   = model_latency(v);
    q.push_back(e);
    last_res = e.exp;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] v, input bit glitch, input bit scramble);
    int i;
    @(negedge clk);
    check("result_held_in_start", result, last_res);
    a    = v;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    push_exp(v);
    check("busy_after_init", busy, 1'b1);
    i = 0;
    while (busy === 1'b1 && i < 200) begin
      if (scramble) a = WIDTH'($urandom);
      if (glitch) init = 1'($urandom_range(0, 1));
      @(negedge clk);
      i++;
    end
    init = 1'b0;
    if (glitch && done === 1'b1) begin
      init = 1'b1;
      @(negedge clk);
      init = 1'b0;
    end
    wait_idle(200);
    @(negedge clk);
    check("no_spurious_start", busy, 1'b0);
  endtask

  task automatic wait_done_fall(input int budget);
    int i;
    i = 0;
    while (done !== 1'b1 && i < budget) begin @(negedge clk); i++; end
    while (done !== 1'b0 && i < budget) begin @(negedge clk); i++; end
    if (i >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got done=%b, expected a done pulse within %0d cycles", done, budget);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    repeat (3) @(negedge clk);
    check("reset_done", done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_result", result, '0);
    rst = 1'b0;

    run_op(16'd3, 1'b0, 1'b0);
    run_op(16'd0, 1'b0, 1'b0);
    run_op(16'hFFFF, 1'b0, 1'b0);

    // init held high: back-to-back runs, each starting only from START
    wait_idle(200);
    @(negedge clk);
    a    = 16'd7;
    init = 1'b1;
    @(negedge clk);
    push_exp(16'd7);
    check("held_busy_run1", busy, 1'b1);
    wait_done_fall(200);
    check("held_start_gap", busy, 1'b0);
    @(negedge clk);
    push_exp(16'd7);
    check("held_busy_run2", busy, 1'b1);
    init = 1'b0;
    wait_done_fall(200);
    wait_idle(200);

    // abort a run of a=100 with rst mid-operation
    @(negedge clk);
    a    = 16'd100;
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    push_exp(16'd100);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", done, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_result", result, '0);
    rst = 1'b0;
    q.delete();
    last_res = '0;
    repeat (120) @(negedge clk);
    check("abort_no_done", done, 1'b0);

    run_op(16'd5, 1'b0, 1'b1);
    run_op(16'h8000, 1'b1, 1'b1);
    run_op(16'd1, 1'b1, 1'b0);
    for (int k = 0; k < 25; k++) begin
      v = WIDTH'($urandom);
      if (k % 5 == 0) v = v >> $urandom_range(0, WIDTH - 1);
      run_op(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    wait_idle(200);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
